opcode_sequencer: RTL
=====================

Name: opcode_sequencer

Overview:
- Producer side of the 9-bit opcode interface consumed by the control unit.
- Sits between instruction fetch and decode. Registers fetched opcodes into the decode stage.
- Injects NOP bubbles after taken branches.
- Injects a hardware interrupt entry sequence (PUSH PC, optional PUSH flags, JMP to vector), encoded with the codebase opcode values.

Parameters:
- FLUSH_CYCLES, 1, number of NOP bubbles injected after branch_taken (1..3).
- OPW, 9, opcode width; fixed at 9 to match the decode interface.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_opcode  in  9  opcode from fetch stage.
- fetch_valid  in  1  fetch_opcode is valid this cycle.
- stall  in  1  hazard stall; freezes all registers of this block.
- branch_taken  in  1  one-cycle pulse from execute; a taken branch or jump.
- int_req  in  1  interrupt request, level, held until int_ack.
- opcode_out  out  9  opcode presented to the control unit.
- opcode_valid  out  1  opcode_out carries a real (non-bubble) instruction.
- inj_src  out  2  operand source for injected ops: 00 normal, 01 PC, 10 flags, 11 interrupt vector.
- fetch_hold  out  1  fetch must not advance PC this cycle.
- int_ack  out  1  one-cycle pulse when the interrupt is accepted.
- busy  out  1  high in any state other than PASS.

Behaviour:
- Reset (async, rst_n=0):
  - state=PASS, opcode_out=9'h000 (NOP), opcode_valid=0, inj_src=00.
  - fetch_hold=0, int_ack=0, flush counter=0, int_pending=0.
  - Reset mid-sequence abandons the sequence; no partial push completes after reset.
- All outputs are registered: one cycle latency from fetch_opcode to opcode_out.
- stall=1: every register holds, including state, counter and outputs. int_ack is forced 0 during stall and re-issued when stall drops. The stall check comes before all other rules.
- int_pending is set when int_req=1 in PASS and cleared on int_ack.
- Priority when not stalled: branch_taken > interrupt entry > normal pass.
- States and transitions:
  - PASS:
    - Outputs: opcode_out=fetch_opcode, opcode_valid=fetch_valid, inj_src=00, fetch_hold=0.
    - If branch_taken=1: go to FLUSH and load counter=FLUSH_CYCLES-1.
    - Else if int_pending: go to INT_PC, pulse int_ack.
  - FLUSH:
    - Outputs: opcode_out=NOP, opcode_valid=0, fetch_hold=0.
    - Counter decrements each cycle; at 0 return to PASS.
    - branch_taken during FLUSH reloads the counter.
    - A pending interrupt waits until PASS.
  - INT_PC:
    - Outputs: opcode_out=PUSH 9'b011_00000, opcode_valid=1, inj_src=01, fetch_hold=1.
    - Next state: INT_FLAGS if FLAGS_PUSH_EN is defined, else INT_JMP.
  - INT_FLAGS:
    - Outputs: opcode_out=PUSH, inj_src=10, fetch_hold=1.
    - Next state: INT_JMP.
  - INT_JMP:
    - Outputs: opcode_out=JMP 9'b100_00100, inj_src=11, fetch_hold=1.
    - Next state: FLUSH, so the fetched-after-vector slot is bubbled.
- branch_taken arriving during INT_* states is ignored; the sequence is atomic.
- fetch_opcode is ignored whenever state is not PASS. fetch_hold keeps the unconsumed instruction at fetch.
- No illegal-opcode checking; unknown opcodes pass through unchanged.
- Unreachable state encodings recover to PASS with NOP output.

Optional Feature:
- Macro: FLAGS_PUSH_EN.
  - Defined: INT_FLAGS state exists. Interrupt entry takes 3 cycles: PUSH PC, PUSH flags, JMP.
  - Undefined: INT_FLAGS is not compiled. Entry takes 2 cycles: PUSH PC, JMP; inj_src never equals 10.

Test Plan:
- Reset mid INT_PC (rst_n low for 2 cycles) -> after release: opcode_out=9'h000, opcode_valid=0, busy=0, int_ack not repeated unless int_req is still high.
- Stream ADD 9'h041, SUB 9'h042, fetch_valid=1 -> opcode_out shows 9'h041 then 9'h042, each 1 cycle after input, inj_src=00.
- branch_taken pulse with FLUSH_CYCLES=2 -> two cycles of opcode_out=9'h000, opcode_valid=0, then fetched opcodes resume.
- int_req=1 in PASS, FLAGS_PUSH_EN undefined:
  - int_ack pulses once.
  - Sequence 9'h060/inj_src=01, then 9'h084/inj_src=11, with fetch_hold=1 for both.
  - Then one NOP bubble, then PASS.
- Same with FLAGS_PUSH_EN defined -> 9'h060/01, 9'h060/10, 9'h084/11, then one bubble.
- int_req and branch_taken in the same cycle, then stall=1 for 3 cycles mid-sequence:
  - FLUSH is taken first; interrupt is entered after FLUSH returns to PASS.
  - Outputs are frozen during stall, then the sequence resumes unaltered.

Source files
------------

// File: rtl/opcode_sequencer_if.sv
// -----------------------------------------------------------------------------
// opcode_sequencer_if
//
// Bundle between instruction fetch, the opcode sequencer and the control unit.
//
//   fetch_opcode  [OPW]  opcode from the fetch stage
//   fetch_valid          fetch_opcode is valid this cycle
//   stall                hazard stall, freezes the sequencer
//   branch_taken         one-cycle pulse from execute (taken branch / jump)
//   int_req              interrupt request, level, held until int_ack
//   opcode_out    [OPW]  opcode presented to the control unit
//   opcode_valid         opcode_out is a real (non-bubble) instruction
//   inj_src       [2]    operand source of injected ops:
//                        00 normal, 01 PC, 10 flags, 11 interrupt vector
//   fetch_hold           fetch must not advance PC this cycle
//   int_ack              one-cycle pulse when the interrupt is accepted
//   busy                 sequencer is in any state other than PASS
//
// Modports:
//   master - the sequencer (drives the decode-side outputs)
//   slave  - the surrounding pipeline (drives fetch/execute-side inputs)
// -----------------------------------------------------------------------------
interface opcode_sequencer_if #(
  parameter int OPW = 9
);

  logic [OPW-1:0] fetch_opcode;
  logic           fetch_valid;
  logic           stall;
  logic           branch_taken;
  logic           int_req;

  logic [OPW-1:0] opcode_out;
  logic           opcode_valid;
  logic [1:0]     inj_src;
  logic           fetch_hold;
  logic           int_ack;
  logic           busy;

  modport master (
    input  fetch_opcode, fetch_valid, stall, branch_taken, int_req,
    output opcode_out, opcode_valid, inj_src, fetch_hold, int_ack, busy
  );

  modport slave (
    output fetch_opcode, fetch_valid, stall, branch_taken, int_req,
    input  opcode_out, opcode_valid, inj_src, fetch_hold, int_ack, busy
  );

endinterface

// File: rtl/opcode_sequencer.sv
// -----------------------------------------------------------------------------
// opcode_sequencer
//
// Registers fetched opcodes into the decode stage, inserts NOP bubbles after a
// taken branch and injects the hardware interrupt entry sequence
// (PUSH PC, optional PUSH flags, JMP vector).
//
// Parameters:
//   FLUSH_CYCLES  number of NOP bubbles after branch_taken (1..3)
//   OPW           opcode width, fixed at 9 to match the decode interface
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    opcode_sequencer_if.master (see the interface file for signals)
//
// Build option:
//   FLAGS_PUSH_EN  when defined, interrupt entry also pushes the flags
//                  (PUSH PC, PUSH flags, JMP); otherwise PUSH PC, JMP only.
// -----------------------------------------------------------------------------
module opcode_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int OPW          = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  opcode_sequencer_if.master  bus
);

  localparam logic [OPW-1:0] OP_NOP  = 9'h000;
  localparam logic [OPW-1:0] OP_PUSH = 9'b011_00000;
  localparam logic [OPW-1:0] OP_JMP  = 9'b100_00100;

  // Counter is loaded with one less than the bubble count: the FLUSH state
  // emits one bubble per cycle, including the cycle in which it reads zero.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PASS      = 3'd0,
    S_FLUSH     = 3'd1,
    S_INT_PC    = 3'd2,
`ifdef FLAGS_PUSH_EN
    S_INT_FLAGS = 3'd3,
`endif
    S_INT_JMP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SRC_NORMAL = 2'b00,
    SRC_PC     = 2'b01,
    SRC_FLAGS  = 2'b10,
    SRC_VECTOR = 2'b11
  } inj_src_t;

  state_t         state_q,   state_d;
  logic [1:0]     cnt_q,     cnt_d;
  logic           pending_q, pending_d;
  logic [OPW-1:0] op_q,      op_d;
  logic           vld_q,     vld_d;
  inj_src_t       src_q,     src_d;
  logic           hold_q,    hold_d;
  logic           ack_q,     ack_d;
  logic           recover;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are registered, so the values
  // computed here describe the state being entered on the next edge.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    op_d      = op_q;
    vld_d     = vld_q;
    src_d     = src_q;
    hold_d    = hold_q;
    ack_d     = ack_q;
    recover   = 1'b0;

    // A stall freezes everything, including the pending int_ack pulse.
    if (!bus.stall) begin
      ack_d = 1'b0;

      case (state_q)
        S_PASS: begin
          if (bus.int_req) pending_d = 1'b1;
          if (bus.branch_taken) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else if (pending_q) begin
            // Acceptance clears the request even if int_req is still high.
            state_d   = S_INT_PC;
            ack_d     = 1'b1;
            pending_d = 1'b0;
          end
        end

        S_FLUSH: begin
          if (bus.branch_taken) begin
            cnt_d = FLUSH_LOAD;
          end else if (cnt_q == 2'd0) begin
            state_d = S_PASS;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end

        // Interrupt entry is atomic: branch_taken is not looked at here.
        S_INT_PC: begin
`ifdef FLAGS_PUSH_EN
          state_d = S_INT_FLAGS;
`else
          state_d = S_INT_JMP;
`endif
        end

`ifdef FLAGS_PUSH_EN
        S_INT_FLAGS: state_d = S_INT_JMP;
`endif

        // The slot fetched right after the vector jump is bubbled.
        S_INT_JMP: begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end

        default: begin
          state_d   = S_PASS;
          cnt_d     = 2'd0;
          pending_d = 1'b0;
          recover   = 1'b1;
        end
      endcase

      case (state_d)
        S_PASS: begin
          op_d   = recover ? OP_NOP : bus.fetch_opcode;
          vld_d  = recover ? 1'b0   : bus.fetch_valid;
          src_d  = SRC_NORMAL;
          hold_d = 1'b0;
        end
        S_INT_PC: begin
          op_d   = OP_PUSH;
          vld_d  = 1'b1;
          src_d  = SRC_PC;
          hold_d = 1'b1;
        end
`ifdef FLAGS_PUSH_EN
        S_INT_FLAGS: begin
          op_d   = OP_PUSH;
          vld_d  = 1'b1;
          src_d  = SRC_FLAGS;
          hold_d = 1'b1;
        end
`endif
        S_INT_JMP: begin
          op_d   = OP_JMP;
          vld_d  = 1'b1;
          src_d  = SRC_VECTOR;
          hold_d = 1'b1;
        end
        default: begin  // S_FLUSH
          op_d   = OP_NOP;
          vld_d  = 1'b0;
          src_d  = SRC_NORMAL;
          hold_d = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_PASS;
      cnt_q     <= 2'd0;
      pending_q <= 1'b0;
      op_q      <= OP_NOP;
      vld_q     <= 1'b0;
      src_q     <= SRC_NORMAL;
      hold_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      op_q      <= op_d;
      vld_q     <= vld_d;
      src_q     <= src_d;
      hold_q    <= hold_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.opcode_out   = op_q;
  assign bus.opcode_valid = vld_q;
  assign bus.inj_src      = src_q;
  assign bus.fetch_hold   = hold_q;
  // The acknowledge is held in its register across a stall and only shown
  // once the stall drops, so the requester never sees it twice.
  assign bus.int_ack      = ack_q & ~bus.stall;
  assign bus.busy         = (state_q != S_PASS);

endmodule
